// File: rtl/axi_sram_slave_if.sv
// axi_sram_slave_if
// AXI4 bus bundle between the core's AXI master port and the SRAM responder.
// Carries the five channels (AW, W, B, AR, R). Clock and reset are not part
// of the bundle; each module receives them as plain ports.
//   slave  modport : used by axi_sram_slave (drives ready/response signals)
//   master modport : used by whatever issues requests (core or testbench)
`timescale 1ns/1ps
interface axi_sram_slave_if;
  // write address channel
  logic        io_slave_awready;
  logic        io_slave_awvalid;
  logic [31:0] io_slave_awaddr;
  logic [3:0]  io_slave_awid;
  logic [7:0]  io_slave_awlen;
  logic [2:0]  io_slave_awsize;
  logic [1:0]  io_slave_awburst;
  // write data channel
  logic        io_slave_wready;
  logic        io_slave_wvalid;
  logic [31:0] io_slave_wdata;
  logic [3:0]  io_slave_wstrb;
  logic        io_slave_wlast;
  // write response channel
  logic        io_slave_bready;
  logic        io_slave_bvalid;
  logic [1:0]  io_slave_bresp;
  logic [3:0]  io_slave_bid;
  // read address channel
  logic        io_slave_arready;
  logic        io_slave_arvalid;
  logic [31:0] io_slave_araddr;
  logic [3:0]  io_slave_arid;
  logic [7:0]  io_slave_arlen;
  logic [2:0]  io_slave_arsize;
  logic [1:0]  io_slave_arburst;
  // read data channel
  logic        io_slave_rready;
  logic        io_slave_rvalid;
  logic [1:0]  io_slave_rresp;
  logic [31:0] io_slave_rdata;
  logic        io_slave_rlast;
  logic [3:0]  io_slave_rid;

  modport slave (
    output io_slave_awready, io_slave_wready, io_slave_bvalid, io_slave_bresp, io_slave_bid,
    output io_slave_arready, io_slave_rvalid, io_slave_rresp, io_slave_rdata, io_slave_rlast,
    output io_slave_rid,
    input  io_slave_awvalid, io_slave_awaddr, io_slave_awid, io_slave_awlen, io_slave_awsize,
    input  io_slave_awburst, io_slave_wvalid, io_slave_wdata, io_slave_wstrb, io_slave_wlast,
    input  io_slave_bready, io_slave_arvalid, io_slave_araddr, io_slave_arid, io_slave_arlen,
    input  io_slave_arsize, io_slave_arburst, io_slave_rready
  );

  modport master (
    input  io_slave_awready, io_slave_wready, io_slave_bvalid, io_slave_bresp, io_slave_bid,
    input  io_slave_arready, io_slave_rvalid, io_slave_rresp, io_slave_rdata, io_slave_rlast,
    input  io_slave_rid,
    output io_slave_awvalid, io_slave_awaddr, io_slave_awid, io_slave_awlen, io_slave_awsize,
    output io_slave_awburst, io_slave_wvalid, io_slave_wdata, io_slave_wstrb, io_slave_wlast,
    output io_slave_bready, io_slave_arvalid, io_slave_araddr, io_slave_arid, io_slave_arlen,
    output io_slave_arsize, io_slave_arburst, io_slave_rready
  );
endinterface

// File: rtl/axi_sram_slave.sv
// axi_sram_slave
// AXI4 responder backed by a word-organised SRAM model. Independent read and
// write engines, configurable response latency, byte-strobe writes, INCR and
// FIXED bursts (WRAP behaves as INCR) and per-beat address-range decode.
// Ports:
//   clock : rising-edge clock
//   reset : synchronous, active-high; abandons any transaction in flight
//   bus   : axi_sram_slave_if.slave (AW/W/B/AR/R channels)
`timescale 1ns/1ps
module axi_sram_slave #(
  parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
  parameter int          DEPTH_WORDS = 4096,
  parameter int          RD_LATENCY  = 1,
  parameter int          WR_LATENCY  = 1
) (
  input logic             clock,
  input logic             reset,
  axi_sram_slave_if.slave bus
);
  localparam int          IDX_W        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] ADDR_END     = {1'b0, ADDR_BASE} + 33'(4 * DEPTH_WORDS);
  localparam logic [15:0] RD_WAIT_INIT = (RD_LATENCY > 0) ? 16'(RD_LATENCY - 1) : 16'd0;
  localparam logic [15:0] WR_WAIT_INIT = (WR_LATENCY > 0) ? 16'(WR_LATENCY - 1) : 16'd0;
  localparam logic [1:0]  RESP_OKAY    = 2'b00;
  localparam logic [1:0]  RESP_SLVERR  = 2'b10;
  localparam logic [1:0]  RESP_DECERR  = 2'b11;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_WAIT, W_RESP} w_state_t;

  logic [31:0] mem [DEPTH_WORDS];

  // 33-bit compare so a window ending exactly at 4 GiB still decodes correctly.
  function automatic logic in_range(input logic [31:0] addr);
    return ({1'b0, addr} >= {1'b0, ADDR_BASE}) && ({1'b0, addr} < ADDR_END);
  endfunction

  function automatic logic [IDX_W-1:0] word_index(input logic [31:0] addr);
    return IDX_W'((addr - ADDR_BASE) >> 2);
  endfunction

  function automatic logic [31:0] step_addr(input logic [31:0] addr, input logic [1:0] burst);
    return (burst == 2'b00) ? addr : addr + 32'd4;
  endfunction

  // size fields are not used: the beat stride is always one word
  logic unused_size;
  assign unused_size = ^{bus.io_slave_awsize, bus.io_slave_arsize};

  // ---------------- read engine ----------------
  r_state_t    r_state, r_next;
  logic [31:0] r_addr, r_fetch_addr, r_data_q;
  logic [3:0]  r_id;
  logic [7:0]  r_len, r_cnt;
  logic [1:0]  r_burst, r_resp_q;
  logic [15:0] r_wait;
  logic        ar_fire, r_fire, r_last, r_load;

  assign ar_fire = bus.io_slave_arvalid && (r_state == R_IDLE);
  assign r_fire  = bus.io_slave_rready && (r_state == R_DATA);
  assign r_last  = (r_cnt == r_len);
  // rdata is refreshed only on the edge that enters R_DATA, so it stays
  // stable while the master stalls.
  assign r_load  = (r_next == R_DATA) && ((r_state != R_DATA) || r_fire);

  always_ff @(posedge clock) begin
    if (reset) r_state <= R_IDLE;
    else       r_state <= r_next;
  end

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (ar_fire) r_next = (RD_LATENCY == 0) ? R_DATA : R_WAIT;
      R_WAIT:  if (r_wait == 16'd0) r_next = R_DATA;
      R_DATA:  if (r_fire) r_next = r_last ? R_IDLE : ((RD_LATENCY == 0) ? R_DATA : R_WAIT);
      default: r_next = R_IDLE;
    endcase
  end

  // With zero latency the fetch happens on the AR or R handshake edge itself,
  // before the address register has been loaded or advanced.
  always_comb begin
    r_fetch_addr = r_addr;
    if (r_state == R_IDLE)      r_fetch_addr = bus.io_slave_araddr;
    else if (r_state == R_DATA) r_fetch_addr = step_addr(r_addr, r_burst);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_addr   <= '0;
      r_id     <= '0;
      r_len    <= '0;
      r_cnt    <= '0;
      r_burst  <= '0;
      r_wait   <= '0;
      r_data_q <= '0;
      r_resp_q <= RESP_OKAY;
    end else begin
      if (ar_fire) begin
        r_addr  <= bus.io_slave_araddr;
        r_id    <= bus.io_slave_arid;
        r_len   <= bus.io_slave_arlen;
        r_burst <= bus.io_slave_arburst;
        r_cnt   <= '0;
      end else if (r_fire && !r_last) begin
        r_addr <= step_addr(r_addr, r_burst);
        r_cnt  <= r_cnt + 8'd1;
      end
      if ((r_next == R_WAIT) && (r_state != R_WAIT)) r_wait <= RD_WAIT_INIT;
      else if (r_state == R_WAIT)                    r_wait <= r_wait - 16'd1;
      if (r_load) begin
        if (in_range(r_fetch_addr)) begin
          r_data_q <= mem[word_index(r_fetch_addr)];
          r_resp_q <= RESP_OKAY;
        end else begin
          r_data_q <= '0;
          r_resp_q <= RESP_DECERR;
        end
      end
    end
  end

  always_comb begin
    bus.io_slave_arready = (r_state == R_IDLE);
    bus.io_slave_rvalid  = (r_state == R_DATA);
    bus.io_slave_rlast   = (r_state == R_DATA) && r_last;
    bus.io_slave_rdata   = r_data_q;
    bus.io_slave_rresp   = r_resp_q;
    bus.io_slave_rid     = r_id;
  end

  // ---------------- write engine ----------------
  w_state_t    w_state, w_next;
  logic [31:0] w_addr;
  logic [3:0]  w_id;
  logic [7:0]  w_len, w_cnt;
  logic [1:0]  w_burst;
  logic [15:0] w_wait;
  logic        w_slverr, w_decerr;
  logic        aw_fire, w_fire, b_fire, w_last;

  assign aw_fire = bus.io_slave_awvalid && (w_state == W_IDLE);
  assign w_fire  = bus.io_slave_wvalid && (w_state == W_DATA);
  assign b_fire  = bus.io_slave_bready && (w_state == W_RESP);
  assign w_last  = (w_cnt == w_len);

  always_ff @(posedge clock) begin
    if (reset) w_state <= W_IDLE;
    else       w_state <= w_next;
  end

  // The burst length comes from awlen; wlast only feeds the SLVERR check.
  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE: if (aw_fire) w_next = W_DATA;
      W_DATA: if (w_fire && w_last) w_next = (WR_LATENCY == 0) ? W_RESP : W_WAIT;
      W_WAIT: if (w_wait == 16'd0) w_next = W_RESP;
      W_RESP: if (b_fire) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      w_addr   <= '0;
      w_id     <= '0;
      w_len    <= '0;
      w_cnt    <= '0;
      w_burst  <= '0;
      w_wait   <= '0;
      w_slverr <= 1'b0;
      w_decerr <= 1'b0;
    end else begin
      if (aw_fire) begin
        w_addr   <= bus.io_slave_awaddr;
        w_id     <= bus.io_slave_awid;
        w_len    <= bus.io_slave_awlen;
        w_burst  <= bus.io_slave_awburst;
        w_cnt    <= '0;
        w_slverr <= 1'b0;
        w_decerr <= 1'b0;
      end else if (w_fire) begin
        if (!in_range(w_addr))               w_decerr <= 1'b1;
        if (bus.io_slave_wlast != w_last)    w_slverr <= 1'b1;
        if (!w_last) begin
          w_addr <= step_addr(w_addr, w_burst);
          w_cnt  <= w_cnt + 8'd1;
        end
      end
      if ((w_next == W_WAIT) && (w_state != W_WAIT)) w_wait <= WR_WAIT_INIT;
      else if (w_state == W_WAIT)                    w_wait <= w_wait - 16'd1;
    end
  end

  // Memory array has no reset; a beat landing on a reset edge is dropped.
  always_ff @(posedge clock) begin
    if (!reset && w_fire && in_range(w_addr)) begin
      if (bus.io_slave_wstrb[0]) mem[word_index(w_addr)][7:0]   <= bus.io_slave_wdata[7:0];
      if (bus.io_slave_wstrb[1]) mem[word_index(w_addr)][15:8]  <= bus.io_slave_wdata[15:8];
      if (bus.io_slave_wstrb[2]) mem[word_index(w_addr)][23:16] <= bus.io_slave_wdata[23:16];
      if (bus.io_slave_wstrb[3]) mem[word_index(w_addr)][31:24] <= bus.io_slave_wdata[31:24];
    end
  end

  // DECERR outranks SLVERR when both occurred in the same burst.
  always_comb begin
    bus.io_slave_awready = (w_state == W_IDLE);
    bus.io_slave_wready  = (w_state == W_DATA);
    bus.io_slave_bvalid  = (w_state == W_RESP);
    bus.io_slave_bid     = w_id;
    if (w_decerr)      bus.io_slave_bresp = RESP_DECERR;
    else if (w_slverr) bus.io_slave_bresp = RESP_SLVERR;
    else               bus.io_slave_bresp = RESP_OKAY;
  end
endmodule

// File: tb/tb_axi_sram_slave.sv
// tb_axi_sram_slave
// Drives randomized and directed AXI traffic into axi_sram_slave and checks
// every response against a word-array reference model of the memory.
`timescale 1ns/1ps
module tb_axi_sram_slave;
  localparam logic [31:0] ADDR_BASE   = 32'h8000_0000;
  localparam int          DEPTH_WORDS = 4096;
  localparam int          RD_LATENCY  = 1;
  localparam int          WR_LATENCY  = 1;
  localparam longint      ADDR_LIMIT  = longint'(ADDR_BASE) + 4 * DEPTH_WORDS;
  localparam int          TIMEOUT     = 50;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  axi_sram_slave_if bus();

  axi_sram_slave #(
    .ADDR_BASE(ADDR_BASE), .DEPTH_WORDS(DEPTH_WORDS),
    .RD_LATENCY(RD_LATENCY), .WR_LATENCY(WR_LATENCY)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] model_mem [DEPTH_WORDS];
  logic [31:0] wr_data [256];
  logic [3:0]  wr_strb [256];

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit model_in_range(input logic [31:0] a);
    return (longint'(a) >= longint'(ADDR_BASE)) && (longint'(a) < ADDR_LIMIT);
  endfunction

  function automatic int model_index(input logic [31:0] a);
    return int'((longint'(a) - longint'(ADDR_BASE)) / 4);
  endfunction

  function automatic logic [31:0] beat_addr(input logic [31:0] start, input logic [1:0] burst, input int beat);
    return (burst == 2'b00) ? start : start + 32'(4 * beat);
  endfunction

  // ---------------- bus transactions ----------------
  // Beat data comes from wr_data/wr_strb. wlast is driven on beat last_at only
  // (last_at == len is a well-formed burst).
  task automatic axi_write(input logic [31:0] addr, input logic [3:0] id, input int len,
                           input logic [1:0] burst, input int last_at, output logic [1:0] resp);
    int         wait_cyc;
    int         hold;
    bit         exp_dec;
    logic [1:0] exp_resp;
    exp_dec = 1'b0;
    for (int i = 0; i <= len; i++) begin
      logic [31:0] a;
      a = beat_addr(addr, burst, i);
      if (!model_in_range(a)) exp_dec = 1'b1;
      else
        for (int b = 0; b < 4; b++)
          if (wr_strb[i][b]) model_mem[model_index(a)][8*b +: 8] = wr_data[i][8*b +: 8];
    end
    exp_resp = exp_dec ? 2'b11 : ((last_at != len) ? 2'b10 : 2'b00);

    bus.io_slave_awvalid = 1'b1;
    bus.io_slave_awaddr  = addr;
    bus.io_slave_awid    = id;
    bus.io_slave_awlen   = 8'(len);
    bus.io_slave_awsize  = 3'd2;
    bus.io_slave_awburst = burst;
    wait_cyc = 0;
    while (!bus.io_slave_awready && wait_cyc < TIMEOUT) begin @(posedge clock); #1; wait_cyc++; end
    if (wait_cyc >= TIMEOUT) checkOutput("aw_timeout", 32'd1, 32'd0);
    @(posedge clock); #1;
    bus.io_slave_awvalid = 1'b0;

    for (int i = 0; i <= len; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        bus.io_slave_wvalid = 1'b0;
        @(posedge clock); #1;
      end
      bus.io_slave_wvalid = 1'b1;
      bus.io_slave_wdata  = wr_data[i];
      bus.io_slave_wstrb  = wr_strb[i];
      bus.io_slave_wlast  = (i == last_at);
      wait_cyc = 0;
      while (!bus.io_slave_wready && wait_cyc < TIMEOUT) begin @(posedge clock); #1; wait_cyc++; end
      if (wait_cyc >= TIMEOUT) checkOutput("w_timeout", 32'd1, 32'd0);
      @(posedge clock); #1;
    end
    bus.io_slave_wvalid = 1'b0;
    bus.io_slave_wlast  = 1'b0;

    wait_cyc = 0;
    while (!bus.io_slave_bvalid && wait_cyc < TIMEOUT) begin @(posedge clock); #1; wait_cyc++; end
    checkOutput("b_latency", 32'(wait_cyc), 32'(WR_LATENCY));
    hold = $urandom_range(0, 2);
    for (int s = 0; s <= hold; s++) begin
      checkOutput("bvalid_hold", 32'(bus.io_slave_bvalid), 32'd1);
      checkOutput("bresp", 32'(bus.io_slave_bresp), 32'(exp_resp));
      checkOutput("bid", 32'(bus.io_slave_bid), 32'(id));
      if (s == hold) bus.io_slave_bready = 1'b1;
      resp = bus.io_slave_bresp;
      @(posedge clock); #1;
    end
    bus.io_slave_bready = 1'b0;
    checkOutput("b_drop", 32'(bus.io_slave_bvalid), 32'd0);
  endtask

  // stall < 0 picks a random number of rready-low cycles per beat.
  task automatic axi_read(input logic [31:0] addr, input logic [3:0] id, input int len,
                          input logic [1:0] burst, input int stall,
                          output logic [31:0] first_data, output logic [1:0] first_resp);
    int          wait_cyc;
    int          n_stall;
    logic [31:0] a, exp_data;
    logic [1:0]  exp_resp;
    bus.io_slave_arvalid = 1'b1;
    bus.io_slave_araddr  = addr;
    bus.io_slave_arid    = id;
    bus.io_slave_arlen   = 8'(len);
    bus.io_slave_arsize  = 3'd2;
    bus.io_slave_arburst = burst;
    wait_cyc = 0;
    while (!bus.io_slave_arready && wait_cyc < TIMEOUT) begin @(posedge clock); #1; wait_cyc++; end
    if (wait_cyc >= TIMEOUT) checkOutput("ar_timeout", 32'd1, 32'd0);
    @(posedge clock); #1;
    bus.io_slave_arvalid = 1'b0;
    first_data = '0;
    first_resp = '0;

    for (int i = 0; i <= len; i++) begin
      a = beat_addr(addr, burst, i);
      exp_data = model_in_range(a) ? model_mem[model_index(a)] : 32'd0;
      exp_resp = model_in_range(a) ? 2'b00 : 2'b11;
      wait_cyc = 0;
      while (!bus.io_slave_rvalid && wait_cyc < TIMEOUT) begin @(posedge clock); #1; wait_cyc++; end
      checkOutput("r_latency", 32'(wait_cyc), 32'(RD_LATENCY));
      n_stall = (stall < 0) ? int'($urandom_range(0, 2)) : stall;
      for (int s = 0; s <= n_stall; s++) begin
        checkOutput("rvalid_hold", 32'(bus.io_slave_rvalid), 32'd1);
        checkOutput("rdata", bus.io_slave_rdata, exp_data);
        checkOutput("rresp", 32'(bus.io_slave_rresp), 32'(exp_resp));
        checkOutput("rlast", 32'(bus.io_slave_rlast), 32'(i == len));
        checkOutput("rid", 32'(bus.io_slave_rid), 32'(id));
        if (i == 0) begin
          first_data = bus.io_slave_rdata;
          first_resp = bus.io_slave_rresp;
        end
        if (s == n_stall) bus.io_slave_rready = 1'b1;
        @(posedge clock); #1;
      end
      bus.io_slave_rready = 1'b0;
    end
    checkOutput("r_drop", 32'(bus.io_slave_rvalid), 32'd0);
    checkOutput("r_idle_arready", 32'(bus.io_slave_arready), 32'd1);
  endtask

  // Random mix of reads and writes, including bursts that straddle either
  // edge of the decoded window and occasional bad wlast placement.
  task automatic applyStimulus(input int n);
    for (int k = 0; k < n; k++) begin
      logic [31:0] addr, d;
      logic [1:0]  burst, r;
      logic [3:0]  id;
      int          len, sel, last_at;
      sel = int'($urandom_range(0, 9));
      if (sel < 7)      addr = ADDR_BASE + 32'($urandom_range(0, DEPTH_WORDS - 1) * 4);
      else if (sel < 9) addr = ADDR_BASE + 32'(4 * DEPTH_WORDS) - 32'(4 * $urandom_range(1, 4));
      else              addr = ADDR_BASE - 32'(4 * $urandom_range(1, 3));
      addr[1:0] = 2'($urandom_range(0, 3));
      len   = int'($urandom_range(0, 7));
      burst = 2'($urandom_range(0, 3));
      id    = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i <= len; i++) begin
          wr_data[i] = $urandom;
          wr_strb[i] = 4'($urandom_range(0, 15));
        end
        last_at = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, len)) - 1 : len;
        axi_write(addr, id, len, burst, last_at, r);
      end else begin
        axi_read(addr, id, len, burst, -1, d, r);
      end
    end
  endtask

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] d;
    logic [1:0]  r;
    bus.io_slave_awvalid = 1'b0; bus.io_slave_awaddr = '0; bus.io_slave_awid = '0;
    bus.io_slave_awlen = '0; bus.io_slave_awsize = '0; bus.io_slave_awburst = '0;
    bus.io_slave_wvalid = 1'b0; bus.io_slave_wdata = '0; bus.io_slave_wstrb = '0;
    bus.io_slave_wlast = 1'b0; bus.io_slave_bready = 1'b0;
    bus.io_slave_arvalid = 1'b0; bus.io_slave_araddr = '0; bus.io_slave_arid = '0;
    bus.io_slave_arlen = '0; bus.io_slave_arsize = '0; bus.io_slave_arburst = '0;
    bus.io_slave_rready = 1'b0;

    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    checkOutput("rst_awready", 32'(bus.io_slave_awready), 32'd1);
    checkOutput("rst_arready", 32'(bus.io_slave_arready), 32'd1);
    checkOutput("rst_wready", 32'(bus.io_slave_wready), 32'd0);
    checkOutput("rst_bvalid", 32'(bus.io_slave_bvalid), 32'd0);
    checkOutput("rst_rvalid", 32'(bus.io_slave_rvalid), 32'd0);
    checkOutput("rst_rlast", 32'(bus.io_slave_rlast), 32'd0);
    checkOutput("rst_rdata", bus.io_slave_rdata, 32'd0);
    checkOutput("rst_resp", 32'({bus.io_slave_bresp, bus.io_slave_rresp}), 32'd0);
    checkOutput("rst_ids", 32'({bus.io_slave_bid, bus.io_slave_rid}), 32'd0);

    // W beats offered before any AW must be refused
    bus.io_slave_wvalid = 1'b1;
    repeat (3) begin
      @(posedge clock); #1;
      checkOutput("w_before_aw", 32'(bus.io_slave_wready), 32'd0);
    end
    bus.io_slave_wvalid = 1'b0;

    // fill the whole memory so every later read has a known expectation
    for (int blk = 0; blk < DEPTH_WORDS / 256; blk++) begin
      for (int i = 0; i < 256; i++) begin
        wr_data[i] = $urandom;
        wr_strb[i] = 4'hF;
      end
      axi_write(ADDR_BASE + 32'(blk * 1024), 4'(blk), 255, 2'b01, 255, r);
    end

    // single read
    wr_data[0] = 32'hDEAD_BEEF; wr_strb[0] = 4'hF;
    axi_write(32'h8000_0010, 4'd1, 0, 2'b01, 0, r);
    checkOutput("single_bresp", 32'(r), 32'd0);
    axi_read(32'h8000_0010, 4'd3, 0, 2'b01, 0, d, r);
    checkOutput("single_rdata", d, 32'hDEAD_BEEF);

    // strobe merge
    wr_data[0] = 32'h1122_3344; wr_strb[0] = 4'hF;
    axi_write(32'h8000_0020, 4'd2, 0, 2'b01, 0, r);
    wr_data[0] = 32'hAABB_CCDD; wr_strb[0] = 4'b0101;
    axi_write(32'h8000_0020, 4'd2, 0, 2'b01, 0, r);
    checkOutput("strobe_bresp", 32'(r), 32'd0);
    axi_read(32'h8000_0020, 4'd4, 0, 2'b01, 0, d, r);
    checkOutput("strobe_rdata", d, 32'h11BB_33DD);

    // INCR read burst with rready toggling
    axi_read(ADDR_BASE, 4'd5, 3, 2'b01, 1, d, r);

    // FIXED write burst: last beat wins
    wr_data[0] = 32'hAAAA_0001; wr_data[1] = 32'hBBBB_0002;
    wr_strb[0] = 4'hF;          wr_strb[1] = 4'hF;
    axi_write(32'h8000_0040, 4'd6, 1, 2'b00, 1, r);
    checkOutput("fixed_bresp", 32'(r), 32'd0);
    axi_read(32'h8000_0040, 4'd6, 0, 2'b01, 0, d, r);
    checkOutput("fixed_rdata", d, 32'hBBBB_0002);

    // early wlast: SLVERR but both beats land
    wr_data[0] = 32'h0123_4567; wr_data[1] = 32'h89AB_CDEF;
    axi_write(32'h8000_0050, 4'd7, 1, 2'b01, 0, r);
    checkOutput("early_wlast_bresp", 32'(r), 32'd2);
    axi_read(32'h8000_0050, 4'd7, 1, 2'b01, 0, d, r);
    checkOutput("early_wlast_rdata0", d, 32'h0123_4567);

    // out-of-range read and write
    axi_read(ADDR_BASE + 32'(4 * DEPTH_WORDS), 4'd8, 0, 2'b01, 0, d, r);
    checkOutput("oor_rdata", d, 32'd0);
    checkOutput("oor_rresp", 32'(r), 32'd3);
    wr_data[0] = 32'hFFFF_FFFF; wr_strb[0] = 4'hF;
    axi_write(ADDR_BASE + 32'(4 * DEPTH_WORDS), 4'd9, 0, 2'b01, 0, r);
    checkOutput("oor_bresp", 32'(r), 32'd3);
    axi_read(ADDR_BASE, 4'd9, 0, 2'b01, 0, d, r);

    // reset while the read engine is waiting on a 4-beat burst
    bus.io_slave_arvalid = 1'b1; bus.io_slave_araddr = ADDR_BASE + 32'h100;
    bus.io_slave_arid = 4'd10; bus.io_slave_arlen = 8'd3; bus.io_slave_arburst = 2'b01;
    @(posedge clock); #1;
    bus.io_slave_arvalid = 1'b0;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    checkOutput("midrst_rvalid", 32'(bus.io_slave_rvalid), 32'd0);
    checkOutput("midrst_arready", 32'(bus.io_slave_arready), 32'd1);
    checkOutput("midrst_rdata", bus.io_slave_rdata, 32'd0);
    repeat (3) begin
      @(posedge clock); #1;
      checkOutput("midrst_quiet", 32'(bus.io_slave_rvalid), 32'd0);
    end
    axi_read(ADDR_BASE + 32'h100, 4'd11, 3, 2'b01, -1, d, r);

    // read and write engines running concurrently on disjoint words
    for (int i = 0; i < 8; i++) begin
      wr_data[i] = $urandom;
      wr_strb[i] = 4'($urandom_range(0, 15));
    end
    fork
      begin
        logic [1:0] wr_r;
        axi_write(ADDR_BASE + 32'h1000, 4'd12, 7, 2'b01, 7, wr_r);
      end
      begin
        logic [31:0] rd_d;
        logic [1:0]  rd_r;
        axi_read(ADDR_BASE + 32'h2000, 4'd13, 7, 2'b01, -1, rd_d, rd_r);
      end
    join
    axi_read(ADDR_BASE + 32'h1000, 4'd14, 7, 2'b01, 0, d, r);

    applyStimulus(80);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/axi_sram_slave.md
Name: axi_sram_slave

Overview:
- AXI4 responder (slave) memory model; the target end of the core's AXI master port.
- Backs instruction fetch and load/store traffic in simulation and in the SoC-less NPC build.
- Independent read (AR/R) and write (AW/W/B) engines with configurable response latency, byte-strobe writes, INCR/FIXED bursts and address-range decode.

Parameters:
ADDR_BASE, 32'h8000_0000, byte address of word 0
DEPTH_WORDS, 4096, number of 32-bit words; index = (addr - ADDR_BASE) >> 2
RD_LATENCY, 1, idle cycles between AR or R handshake and the next rvalid (0 allowed)
WR_LATENCY, 1, idle cycles between the final W beat and bvalid (0 allowed)

Ports:
clock  in  1  single clock, rising edge
reset  in  1  synchronous, active-high
io_slave_awready  out  1  write address accept
io_slave_awvalid  in  1  write address valid
io_slave_awaddr  in  32  write start byte address
io_slave_awid  in  4  write transaction id
io_slave_awlen  in  8  beats minus one
io_slave_awsize  in  3  ignored; beat stride fixed at 4 bytes
io_slave_awburst  in  2  00 FIXED, else INCR (WRAP treated as INCR)
io_slave_wready  out  1  write data accept
io_slave_wvalid  in  1  write data valid
io_slave_wdata  in  32  write data
io_slave_wstrb  in  4  byte enables
io_slave_wlast  in  1  final beat marker
io_slave_bready  in  1  response accept
io_slave_bvalid  out  1  write response valid
io_slave_bresp  out  2  00 OKAY, 10 SLVERR, 11 DECERR
io_slave_bid  out  4  echoes awid
io_slave_arready  out  1  read address accept
io_slave_arvalid  in  1  read address valid
io_slave_araddr  in  32  read start byte address
io_slave_arid  in  4  read transaction id
io_slave_arlen  in  8  beats minus one
io_slave_arsize  in  3  ignored
io_slave_arburst  in  2  as awburst
io_slave_rready  in  1  read data accept
io_slave_rvalid  out  1  read data valid
io_slave_rresp  out  2  00 OKAY, 11 DECERR
io_slave_rdata  out  32  read data
io_slave_rlast  out  1  final beat
io_slave_rid  out  4  echoes arid

Behaviour:
- Reset: state forced to idle on the first reset edge. Afterwards awready=1, arready=1, wready=0, bvalid=0, rvalid=0, rlast=0, rdata=0, bresp=rresp=0, bid=rid=0. Memory contents are not cleared. Reset mid-burst abandons the transaction with no response.
- Read FSM R_IDLE/R_WAIT/R_DATA:
  - R_IDLE: arready=1. On AR handshake, latch addr, id, len and burst; beat count = 0.
  - Go to R_WAIT for RD_LATENCY cycles, or straight to R_DATA if RD_LATENCY=0.
  - On the edge entering R_DATA, register rdata from memory at the current address.
  - R_DATA: rvalid=1; rdata, rresp, rlast and rid are held stable until rready. rlast=1 when beat count == len.
  - On R handshake: if last, go to R_IDLE; otherwise advance the address (+4 for INCR, unchanged for FIXED), increment the count, and repeat the wait/fetch.
  - Timing: AR handshake in cycle t gives rvalid in cycle t+1+RD_LATENCY. Each later beat follows its previous R handshake by the same interval.
- Write FSM W_IDLE/W_DATA/W_WAIT/W_RESP:
  - W_IDLE: awready=1, wready=0. W beats presented before the AW handshake are not accepted.
  - W_DATA: wready=1. On each W handshake, write the bytes enabled in wstrb (byte i = wdata[8i+7:8i]) and advance the address as for reads.
  - The burst ends on handshake of beat awlen+1, regardless of wlast. If wlast does not match the final beat (asserted early or missing), bresp=SLVERR; data is still written.
  - W_WAIT: WR_LATENCY cycles. W_RESP: bvalid=1, bid=latched awid, held until bready, then return to W_IDLE.
- Decode:
  - An address below ADDR_BASE or at/above ADDR_BASE+4*DEPTH_WORDS is out of range. The check is per beat, so a burst may cross the boundary.
  - Out-of-range read beat: rdata=0, rresp=DECERR.
  - Out-of-range write beat: ignored, and sticky DECERR is reported in bresp (DECERR takes precedence over SLVERR).
  - The low 2 address bits are ignored for indexing.
- Concurrency:
  - Read and write engines run independently.
  - If a write beat and a read fetch hit the same word on the same edge, the read returns the pre-write data.
  - awready and arready depend only on their own FSM state.

Test Plan:
- Single read: write 0xDEADBEEF at 0x8000_0010, then AR addr=0x8000_0010 len=0 id=3 with rready=1 -> rvalid in cycle t+2 (RD_LATENCY=1), rdata=0xDEADBEEF, rlast=1, rid=3, rresp=00.
- Strobe write: preload 0x11223344; AW 0x8000_0020, W wdata=0xAABBCCDD wstrb=0101 -> bvalid with bresp=00; readback 0x11BB33DD.
- Read burst INCR len=3 from 0x8000_0000 with rready toggling 1/0 -> four beats of words 0..3; rdata stable while stalled; rlast only on beat 4.
- FIXED write burst len=1 to 0x8000_0040 with data A then B -> word holds B. A separate INCR len=1 burst with wlast asserted on beat 1 -> bresp=10, both beats written.
- Out-of-range: AR at ADDR_BASE+4*DEPTH_WORDS -> rdata=0, rresp=11; AW there -> bresp=11, memory unchanged.
- Reset asserted during R_WAIT of a 4-beat burst -> after reset, rvalid=0 and arready=1; a fresh read returns correct data.
